// File: rtl/btn_write_ctrl.sv
// Purpose : debounces the store push-button and emits one write strobe per press,
//           carrying the synchronised digit value and address (manual or auto-increment).
// Latency : write rises DEBOUNCE_CYCLES+3 clocks after btn_in goes high; there is no
//           backpressure. At most one strobe per press/release cycle, and none while held.
// Ports   : clk, rst (sync, active-high), btn_in (raw button), sw_num[3:0] / sw_sel[2:0]
//           (value/address switches), auto_inc (address from internal pointer);
//           num[3:0] / sel[2:0] (captured value/address), write (strobe), busy (FSM not idle).
module btn_write_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   input  logic [3:0] sw_num,
   input  logic [2:0] sw_sel,
   input  logic       auto_inc,
   output logic [3:0] num,
   output logic [2:0] sel,
   output logic       write,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Two-flop synchronisers; the *_s_q copies are the only ones the logic looks at.
   logic       btn_s1_q, btn_s_q;
   logic [3:0] num_s1_q, num_s_q;
   logic [2:0] sel_s1_q, sel_s_q;
   logic       auto_s1_q, auto_s_q;

   state_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0] ptr_q, ptr_d;
   logic [3:0] num_q, num_d;
   logic [2:0] sel_q, sel_d;
   logic       write_q, write_d;
   logic [2:0] wr_addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_s1_q  <= 1'b0;
         btn_s_q   <= 1'b0;
         num_s1_q  <= '0;
         num_s_q   <= '0;
         sel_s1_q  <= '0;
         sel_s_q   <= '0;
         auto_s1_q <= 1'b0;
         auto_s_q  <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= '0;
         ptr_q     <= '0;
         num_q     <= '0;
         sel_q     <= '0;
         write_q   <= 1'b0;
      end else begin
         btn_s1_q  <= btn_in;
         btn_s_q   <= btn_s1_q;
         num_s1_q  <= sw_num;
         num_s_q   <= num_s1_q;
         sel_s1_q  <= sw_sel;
         sel_s_q   <= sel_s1_q;
         auto_s1_q <= auto_inc;
         auto_s_q  <= auto_s1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         num_q     <= num_d;
         sel_q     <= sel_d;
         write_q   <= write_d;
      end
   end

   // Address used by a write; the pointer then continues from it, so leaving
   // manual mode resumes just after the last manually chosen digit.
   assign wr_addr = auto_s_q ? ptr_q : sel_s_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      num_d   = num_q;
      sel_d   = sel_q;
      write_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (btn_s_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!btn_s_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               // The only edge that produces a write.
               state_d = PRESSED;
               cnt_d   = '0;
               write_d = 1'b1;
               num_d   = num_s_q;
               sel_d   = wr_addr;
               ptr_d   = wr_addr + 3'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!btn_s_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (btn_s_q) begin
               // Release bounce: go back to held without a new write.
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign num   = num_q;
   assign sel   = sel_q;
   assign write = write_q;
   assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_btn_write_ctrl.sv
// Purpose : self-checking bench for btn_write_ctrl with DEBOUNCE_CYCLES=4.
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure : none.
module tb_btn_write_ctrl;
   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_in;
   logic [3:0] sw_num;
   logic [2:0] sw_sel;
   logic       auto_inc;
   logic [3:0] num;
   logic [2:0] sel;
   logic       write;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   btn_write_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .btn_in(btn_in), .sw_num(sw_num), .sw_sel(sw_sel),
      .auto_inc(auto_inc), .num(num), .sel(sel), .write(write), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: a level is accepted once the synchronised button has
   // disagreed with the accepted level for D+1 consecutive samples; a write
   // happens whenever the accepted level becomes 1.
   logic       m_b1, m_b2, m_a1, m_a2, m_acc, m_write;
   logic [3:0] m_n1, m_n2, m_num;
   logic [2:0] m_s1, m_s2, m_sel, m_ptr;
   int         m_run;

   function automatic logic m_busy();
      return m_acc || (m_run > 0);
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_b1 = 0; m_b2 = 0; m_a1 = 0; m_a2 = 0; m_acc = 0; m_write = 0;
         m_n1 = 0; m_n2 = 0; m_num = 0; m_s1 = 0; m_s2 = 0; m_sel = 0; m_ptr = 0;
         m_run = 0;
      end else begin
         m_write = 0;
         if (m_b2 != m_acc) begin
            m_run++;
            if (m_run == D + 1) begin
               m_acc = ~m_acc;
               m_run = 0;
               if (m_acc) begin
                  m_write = 1;
                  m_num   = m_n2;
                  m_sel   = m_a2 ? m_ptr : m_s2;
                  m_ptr   = m_sel + 3'd1;
               end
            end
         end else begin
            m_run = 0;
         end
         m_b2 = m_b1; m_b1 = btn_in;
         m_n2 = m_n1; m_n1 = sw_num;
         m_s2 = m_s1; m_s1 = sw_sel;
         m_a2 = m_a1; m_a1 = auto_inc;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1; btn_in = 0;
      tick(); tick();
      rst = 0;
   endtask

   task automatic test_reset();
      rst = 1; btn_in = 1; sw_num = 4'hF; sw_sel = 3'h7; auto_inc = 1;
      tick(); tick();
      n_checks++;
      if ({write, busy, num, sel} !== 9'd0) begin
         n_fail++;
         $display("FAIL reset: write=%b busy=%b num=%h sel=%0d, required all zero", write, busy, num, sel);
      end
      rst = 0; btn_in = 0;
      tick();
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b required 0", busy); end
   endtask

   task automatic test_single_press();
      int wcount = 0;
      int wcyc = -1;
      do_reset();
      sw_num = 4'h9; sw_sel = 3'd3; auto_inc = 0;
      for (int i = 0; i < 40; i++) begin
         btn_in = (i < 20);
         tick();
         n_checks++;
         if (write !== m_write || busy !== m_busy()) begin
            n_fail++;
            $display("FAIL single_press cyc %0d: write=%b busy=%b, required %b %b", i, write, busy, m_write, m_busy());
         end
         if (write === 1'b1) begin
            wcount++;
            if (wcyc < 0) wcyc = i;
            n_checks++;
            if (num !== 4'h9 || sel !== 3'd3) begin
               n_fail++;
               $display("FAIL single_press data: num=%h sel=%0d, required 9 3", num, sel);
            end
         end
      end
      n_checks++;
      if (wcount != 1 || wcyc != D + 2) begin
         n_fail++;
         $display("FAIL single_press pulse: count=%0d edge=%0d, required 1 at edge %0d", wcount, wcyc, D + 2);
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL single_press end busy=%b required 0", busy); end
   endtask

   task automatic test_glitch();
      int wcount = 0;
      logic seen_busy = 0;
      do_reset();
      for (int i = 0; i < 15; i++) begin
         btn_in = (i < 3);
         tick();
         if (busy === 1'b1) seen_busy = 1;
         if (write === 1'b1) wcount++;
         n_checks++;
         if (write !== m_write || busy !== m_busy()) begin
            n_fail++;
            $display("FAIL glitch cyc %0d: write=%b busy=%b, required %b %b", i, write, busy, m_write, m_busy());
         end
      end
      n_checks++;
      if (wcount != 0 || seen_busy !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch summary: writes=%0d saw_busy=%b end_busy=%b, required 0 1 0", wcount, seen_busy, busy);
      end
   endtask

   task automatic test_release_bounce();
      int wcount = 0;
      logic pattern [$];
      do_reset();
      sw_num = 4'(($urandom)); sw_sel = 3'(($urandom)); auto_inc = 0;
      for (int i = 0; i < 10; i++) pattern.push_back(1);
      pattern.push_back(0); pattern.push_back(0); pattern.push_back(1);
      for (int i = 0; i < 10; i++) pattern.push_back(0);
      foreach (pattern[i]) begin
         btn_in = pattern[i];
         tick();
         if (write === 1'b1) wcount++;
         n_checks++;
         if (write !== m_write || busy !== m_busy()) begin
            n_fail++;
            $display("FAIL bounce cyc %0d: write=%b busy=%b, required %b %b", i, write, busy, m_write, m_busy());
         end
      end
      n_checks++;
      if (wcount != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce summary: writes=%0d busy=%b, required 1 0", wcount, busy);
      end
   endtask

   task automatic test_auto_inc();
      logic [3:0] got_num [9];
      logic [2:0] got_sel [9];
      int wcount = 0;
      do_reset();
      auto_inc = 1;
      for (int p = 0; p < 9; p++) begin
         sw_num = 4'(p);
         sw_sel = 3'($urandom);
         for (int i = 0; i < 16; i++) begin
            btn_in = (i < 8);
            tick();
            n_checks++;
            if (write !== m_write || busy !== m_busy()) begin
               n_fail++;
               $display("FAIL auto_inc press %0d cyc %0d: write=%b busy=%b, required %b %b", p, i, write, busy, m_write, m_busy());
            end
            if (write === 1'b1 && wcount < 9) begin
               got_num[wcount] = num; got_sel[wcount] = sel; wcount++;
            end
         end
      end
      n_checks++;
      if (wcount != 9) begin n_fail++; $display("FAIL auto_inc count: %0d writes, required 9", wcount); end
      for (int p = 0; p < wcount; p++) begin
         n_checks++;
         if (got_num[p] !== 4'(p) || got_sel[p] !== 3'(p % 8)) begin
            n_fail++;
            $display("FAIL auto_inc write %0d: num=%0d sel=%0d, required %0d %0d", p, got_num[p], got_sel[p], p, p % 8);
         end
      end
   endtask

   task automatic test_reset_mid_press();
      int wcount = 0;
      int wk = -1;
      do_reset();
      sw_num = 4'h5; sw_sel = 3'd2; auto_inc = 0;
      btn_in = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (write === 1'b1) wcount++;
      end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_reset pre: busy=%b required 1", busy); end
      rst = 1;
      tick();
      rst = 0;
      n_checks++;
      if (busy !== 1'b0 || write !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset in reset: busy=%b write=%b required 0 0", busy, write);
      end
      for (int k = 1; k <= 12; k++) begin
         tick();
         n_checks++;
         if (write !== m_write || busy !== m_busy()) begin
            n_fail++;
            $display("FAIL mid_reset k=%0d: write=%b busy=%b, required %b %b", k, write, busy, m_write, m_busy());
         end
         if (write === 1'b1) begin wcount++; if (wk < 0) wk = k; end
      end
      n_checks++;
      if (wcount != 1 || wk != D + 3) begin
         n_fail++;
         $display("FAIL mid_reset pulse: count=%0d at k=%0d, required 1 at k=%0d", wcount, wk, D + 3);
      end
      btn_in = 0;
   endtask

   task automatic test_manual_to_auto();
      logic [2:0] got [2];
      int wcount = 0;
      do_reset();
      for (int p = 0; p < 2; p++) begin
         auto_inc = (p == 1);
         sw_sel   = (p == 0) ? 3'd5 : 3'd1;
         sw_num   = 4'($urandom);
         for (int i = 0; i < 16; i++) begin
            btn_in = (i < 8);
            tick();
            n_checks++;
            if (write !== m_write || sel !== m_sel || num !== m_num) begin
               n_fail++;
               $display("FAIL manual_to_auto p%0d cyc %0d: write=%b sel=%0d num=%0d, required %b %0d %0d", p, i, write, sel, num, m_write, m_sel, m_num);
            end
            if (write === 1'b1 && wcount < 2) begin got[wcount] = sel; wcount++; end
         end
      end
      n_checks++;
      if (wcount != 2 || got[0] !== 3'd5 || got[1] !== 3'd6) begin
         n_fail++;
         $display("FAIL manual_to_auto sel: count=%0d sels=%0d,%0d, required 2 writes 5,6", wcount, got[0], got[1]);
      end
   endtask

   task automatic test_random();
      int run_left = 0;
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         if (run_left == 0) begin
            btn_in   = ~btn_in;
            run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 12));
         end
         run_left--;
         if ($urandom_range(0, 15) == 0) sw_num = 4'($urandom);
         if ($urandom_range(0, 15) == 0) sw_sel = 3'($urandom);
         if ($urandom_range(0, 63) == 0) auto_inc = ~auto_inc;
         tick();
         n_checks++;
         if (write !== m_write || busy !== m_busy() || num !== m_num || sel !== m_sel) begin
            n_fail++;
            $display("FAIL random cyc %0d: write=%b busy=%b num=%h sel=%0d, required %b %b %h %0d", i, write, busy, num, sel, m_write, m_busy(), m_num, m_sel);
         end
      end
   endtask

   initial begin
      rst = 1; btn_in = 0; sw_num = 0; sw_sel = 0; auto_inc = 0;
      test_reset();
      test_single_press();
      test_glitch();
      test_release_bounce();
      test_auto_inc();
      test_reset_mid_press();
      test_manual_to_auto();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
